// File: rtl/cache_pkg.sv
// Shared types and address-geometry helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

  function automatic int off_w(int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int word_w(int wpb);
    return $clog2(wpb);
  endfunction

  function automatic int set_w(int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(int aw, int dw, int sets, int wpb);
    return aw - off_w(dw) - word_w(wpb) - set_w(sets);
  endfunction

  // Byte address of word 'beat' inside the line holding 'addr'.
  function automatic logic [63:0] beat_addr(logic [63:0] addr, int bo, int wo, int beat);
    logic [63:0] line;
    line = (addr >> (bo + wo)) << (bo + wo);
    return line | (64'(beat) << bo);
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// CPU-side and memory-side signal bundle of the cache.
interface set_assoc_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_rd_en;
  logic                  cpu_wr_en;
  logic                  invalid;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_w_data;
  logic [DATA_WIDTH-1:0] cpu_r_data;
  logic                  cpu_hit;
  logic                  cpu_stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_w_data;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_r_data;

  modport slave (
    input  cpu_rd_en, cpu_wr_en, invalid, cpu_addr, cpu_w_data, mem_ack, mem_r_data,
    output cpu_r_data, cpu_hit, cpu_stall, mem_req, mem_we, mem_addr, mem_w_data
  );

  modport master (
    output cpu_rd_en, cpu_wr_en, invalid, cpu_addr, cpu_w_data, mem_ack, mem_r_data,
    input  cpu_r_data, cpu_hit, cpu_stall, mem_req, mem_we, mem_addr, mem_w_data
  );
endinterface

// File: rtl/cache_way.sv
// One cache way: valid bits, tag and data arrays, single write port,
// combinational tag compare and word read for the addressed set.
module cache_way #(
  parameter  int SETS  = 8,
  parameter  int WPB   = 4,
  parameter  int TAG_W = 25,
  parameter  int DW    = 32,
  localparam int SW    = $clog2(SETS),
  localparam int WO    = $clog2(WPB)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inv_i,
  input  logic [SW-1:0]    set_i,
  input  logic [WO-1:0]    word_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             hit_o,
  output logic             vld_o,
  output logic [DW-1:0]    rdata_o,
  input  logic             we_i,
  input  logic [WO-1:0]    wword_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic             fill_i
);
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [DW-1:0]    data_q [SETS][WPB];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       valid_q <= '0;
    else if (inv_i)  valid_q <= '0;
    else if (fill_i) valid_q[set_i] <= 1'b1;
  end

  // Storage arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_i) tag_q[set_i] <= tag_i;
    if (we_i)   data_q[set_i][wword_i] <= wdata_i;
  end

  assign vld_o   = valid_q[set_i];
  assign hit_o   = vld_o && (tag_q[set_i] == tag_i);
  assign rdata_o = data_q[set_i][word_i];
endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through cache: refill FSM over a req/ack memory
// port, LRU replacement, no-write-allocate stores and a pipeline stall.
module set_assoc_cache import cache_pkg::*; #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SETS            = 8,
  parameter int WAYS            = 2,
  parameter int WORDS_PER_BLOCK = 4
) (
  input logic               clk,
  input logic               reset,
  set_assoc_cache_if.slave  bus
);
  localparam int BO = off_w(DATA_WIDTH);
  localparam int WO = word_w(WORDS_PER_BLOCK);
  localparam int SW = set_w(SETS);
  localparam int TW = tag_w(ADDR_WIDTH, DATA_WIDTH, SETS, WORDS_PER_BLOCK);

  logic [WO-1:0] word;
  logic [SW-1:0] set;
  logic [TW-1:0] tag;
  assign word = bus.cpu_addr[BO +: WO];
  assign set  = bus.cpu_addr[BO+WO +: SW];
  assign tag  = bus.cpu_addr[ADDR_WIDTH-1 -: TW];

  state_e        state_q, state_d;
  logic [WO-1:0] beat_q, beat_d;
  logic          vic_q, vic_d;
  logic          done_q, done_d;

  logic [WAYS-1:0]                 hit_w, vld_w, way_we, way_fill;
  logic [WAYS-1:0][DATA_WIDTH-1:0] rdat_w;
  logic                  inv_all, hit_any, hit_idx, victim, mru_en, mru_way;
  logic [WO-1:0]         wword;
  logic [DATA_WIDTH-1:0] wdata, rdata_sel;
  logic                  hit_c, stall_c, req_c, we_c;
  logic [ADDR_WIDTH-1:0] maddr_c;
  logic [DATA_WIDTH-1:0] mwd_c;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(.SETS(SETS), .WPB(WORDS_PER_BLOCK), .TAG_W(TW), .DW(DATA_WIDTH)) u_way (
      .clk(clk), .reset(reset), .inv_i(inv_all),
      .set_i(set), .word_i(word), .tag_i(tag),
      .hit_o(hit_w[w]), .vld_o(vld_w[w]), .rdata_o(rdat_w[w]),
      .we_i(way_we[w]), .wword_i(wword), .wdata_i(wdata), .fill_i(way_fill[w])
    );
  end

  always_comb begin
    hit_idx   = 1'b0;
    rdata_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_w[w]) begin
        hit_idx   = 1'(w);
        rdata_sel = rdata_sel | rdat_w[w];
      end
    end
  end
  assign hit_any = |hit_w;

  // lru_q[s] names the way to evict next in set s.
  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru_q, lru_d;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) lru_q <= '0;
      else       lru_q <= lru_d;
    end
    always_comb begin
      lru_d = lru_q;
      if (mru_en) lru_d[set] = ~mru_way;
    end
    assign victim = !vld_w[0] ? 1'b0 : (!vld_w[1] ? 1'b1 : lru_q[set]);
  end else begin : g_nolru
    assign victim = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      vic_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      vic_q   <= vic_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    vic_d    = vic_q;
    done_d   = 1'b0;
    way_we   = '0;
    way_fill = '0;
    inv_all  = 1'b0;
    mru_en   = 1'b0;
    mru_way  = hit_idx;
    wword    = word;
    wdata    = bus.cpu_w_data;
    hit_c    = 1'b0;
    stall_c  = 1'b0;
    req_c    = 1'b0;
    we_c     = 1'b0;
    maddr_c  = '0;
    mwd_c    = '0;
    unique case (state_q)
      IDLE: begin
        inv_all = bus.invalid;
        hit_c   = hit_any && !bus.invalid;
        // done_q marks the cycle a finished store is released to the core.
        if (bus.cpu_wr_en && done_q) begin
        end else if (bus.invalid) begin
          stall_c = bus.cpu_rd_en || bus.cpu_wr_en;
        end else if (bus.cpu_wr_en) begin
          stall_c = 1'b1;
          state_d = WRITE;
          if (hit_any) begin
            way_we[hit_idx] = 1'b1;
            mru_en          = 1'b1;
          end
        end else if (bus.cpu_rd_en) begin
          if (hit_any) begin
            mru_en = 1'b1;
          end else begin
            stall_c = 1'b1;
            vic_d   = victim;
            beat_d  = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        maddr_c = ADDR_WIDTH'(beat_addr(64'(bus.cpu_addr), BO, WO, int'(beat_q)));
        wword   = beat_q;
        wdata   = bus.mem_r_data;
        if (bus.mem_ack) begin
          way_we[vic_q] = 1'b1;
          beat_d        = beat_q + 1'b1;
          if (beat_q == WO'(WORDS_PER_BLOCK - 1)) begin
            way_fill[vic_q] = 1'b1;
            mru_en          = 1'b1;
            mru_way         = vic_q;
            state_d         = IDLE;
          end
        end
      end
      WRITE: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        we_c    = 1'b1;
        maddr_c = ADDR_WIDTH'((64'(bus.cpu_addr) >> BO) << BO);
        mwd_c   = bus.cpu_w_data;
        if (bus.mem_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cpu_hit    = hit_c;
  assign bus.cpu_r_data = hit_c ? rdata_sel : '0;
  assign bus.cpu_stall  = stall_c;
  assign bus.mem_req    = req_c;
  assign bus.mem_we     = we_c;
  assign bus.mem_addr   = maddr_c;
  assign bus.mem_w_data = mwd_c;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: a recency-list cache model and a flat
// memory image predict each access; a monitor checks completions against them.
module tb_set_assoc_cache;
  localparam int AW = 32, DW = 32, SETS = 8, WAYS = 2, WPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  set_assoc_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  set_assoc_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETS(SETS), .WAYS(WAYS),
                    .WORDS_PER_BLOCK(WPB)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          stall1;
    int          beats;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0, passes = 0;
  bit          mon_en = 1'b1, force0 = 1'b0;
  logic [31:0] mem  [int unsigned];
  logic [31:0] refm [int unsigned];
  int unsigned rset [SETS][$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_val(a);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < SETS; i++) rset[i].delete();
  endfunction

  // Each set is a recency list, most recent first, at most WAYS tags long.
  function automatic bit model_touch(int unsigned s, int unsigned t, bit alloc);
    for (int i = 0; i < rset[s].size(); i++) begin
      if (rset[s][i] == t) begin
        rset[s].delete(i);
        rset[s].push_front(t);
        return 1'b1;
      end
    end
    if (alloc) begin
      rset[s].push_front(t);
      if (rset[s].size() > WAYS) void'(rset[s].pop_back());
    end
    return 1'b0;
  endfunction

  task automatic do_op(bit wr, logic [31:0] addr, logic [31:0] data, bit inv);
    exp_t        e;
    bit          hit;
    int          n;
    logic [31:0] wa;
    wa = addr & ~32'h3;
    if (inv) model_clear();
    hit      = model_touch((addr >> 4) & 32'h7, addr >> 7, !wr);
    e.wr     = wr;
    e.addr   = addr;
    e.stall1 = wr || !hit;
    e.beats  = wr ? 1 : (hit ? 0 : WPB);
    if (wr) begin
      refm[wa] = data;
      e.data   = data;
    end else begin
      e.data = ref_rd(wa);
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.cpu_rd_en  = !wr;
    bus.cpu_wr_en  = wr;
    bus.cpu_addr   = addr;
    bus.cpu_w_data = wr ? data : 32'h0;
    bus.invalid    = inv;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.cpu_stall) break;
      n++;
      if (n > 200) begin
        checks++;
        $display("FAIL stall timeout: addr %0h still stalled after %0d cycles", addr, n);
        break;
      end
      @(posedge clk); #1;
      bus.invalid = 1'b0;
    end
    @(posedge clk); #1;
    bus.cpu_rd_en = 1'b0;
    bus.cpu_wr_en = 1'b0;
    bus.invalid   = 1'b0;
  endtask

  // Memory responder: random ack latency, checks the beat is held stable.
  initial begin
    logic [31:0] a, d;
    logic        we, stable;
    int          dly;
    bus.mem_ack    = 1'b0;
    bus.mem_r_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
        a      = bus.mem_addr;
        we     = bus.mem_we;
        d      = bus.mem_w_data;
        stable = 1'b1;
        dly    = force0 ? 0 : int'($urandom_range(0, 5));
        repeat (dly) begin
          @(posedge clk); #1;
          if (bus.mem_req !== 1'b1 || bus.mem_addr !== a || bus.mem_we !== we) stable = 1'b0;
        end
        chk("beat held until ack", 64'(stable), 64'(1));
        bus.mem_ack    = 1'b1;
        bus.mem_r_data = we ? 32'h0 : mem_rd(a);
        if (we) mem[a] = d;
      end
    end
  end

  // Monitor: tracks the in-flight request and scores it when stall drops.
  initial begin
    exp_t        cur;
    bit          in_req;
    logic        fst, wwe;
    logic [31:0] waddr, wdat;
    int          nb;
    in_req = 1'b0; fst = 1'b0; wwe = 1'b0; waddr = '0; wdat = '0; nb = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        in_req = 1'b0;
        continue;
      end
      if (bus.cpu_rd_en || bus.cpu_wr_en) begin
        if (!in_req) begin
          in_req = 1'b1;
          fst    = bus.cpu_stall;
          nb     = 0;
        end
        if (bus.mem_req && bus.mem_ack && sbq.size() > 0) begin
          cur = sbq[0];
          if (cur.wr) begin
            wwe = bus.mem_we; waddr = bus.mem_addr; wdat = bus.mem_w_data;
          end else begin
            chk("refill beat we/addr", {31'h0, bus.mem_we, bus.mem_addr},
                {32'h0, (cur.addr & ~32'hF) + 32'(4 * nb)});
          end
          nb++;
        end
        if (!bus.cpu_stall) begin
          in_req = 1'b0;
          if (sbq.size() == 0) begin
            checks++;
            $display("FAIL scoreboard: completion with no expected entry, addr %0h", bus.cpu_addr);
          end else begin
            cur = sbq.pop_front();
            chk("first-cycle stall", 64'(fst), 64'(cur.stall1));
            chk("memory beats", 64'(nb), 64'(cur.beats));
            if (cur.wr) begin
              chk("write beat we/addr", {31'h0, wwe, waddr}, {32'h1, cur.addr & ~32'h3});
              chk("write beat data", 64'(wdat), 64'(cur.data));
            end else begin
              chk("read hit", 64'(bus.cpu_hit), 64'(1));
              chk("read data", 64'(bus.cpu_r_data), 64'(cur.data));
            end
          end
        end
      end
    end
  end

  initial begin
    bus.cpu_rd_en  = 1'b0;
    bus.cpu_wr_en  = 1'b0;
    bus.invalid    = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset cpu_hit", 64'(bus.cpu_hit), 64'(0));
    chk("reset cpu_stall", 64'(bus.cpu_stall), 64'(0));
    chk("reset mem_req", 64'(bus.mem_req), 64'(0));
    chk("reset mem_we", 64'(bus.mem_we), 64'(0));
    chk("reset mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("reset cpu_r_data", 64'(bus.cpu_r_data), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    do_op(1'b0, 32'h104, 32'h0, 1'b0);
    do_op(1'b0, 32'h108, 32'h0, 1'b0);
    do_op(1'b0, 32'h180, 32'h0, 1'b0);
    do_op(1'b0, 32'h100, 32'h0, 1'b0);
    do_op(1'b0, 32'h200, 32'h0, 1'b0);
    do_op(1'b0, 32'h100, 32'h0, 1'b0);
    do_op(1'b0, 32'h180, 32'h0, 1'b0);
    do_op(1'b1, 32'h104, 32'hDEADBEEF, 1'b0);
    do_op(1'b0, 32'h104, 32'h0, 1'b0);
    do_op(1'b1, 32'h400, 32'h12345678, 1'b0);
    do_op(1'b0, 32'h400, 32'h0, 1'b0);

    @(posedge clk); #1 bus.invalid = 1'b1;
    @(posedge clk); #1 bus.invalid = 1'b0;
    model_clear();
    do_op(1'b0, 32'h100, 32'h0, 1'b0);
    do_op(1'b0, 32'h104, 32'h0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      do_op(($urandom % 4) == 0, $urandom_range(0, 127) << 2, $urandom, ($urandom % 20) == 0);
    end

    // Reset in the middle of a refill, on the third beat.
    mon_en = 1'b0;
    force0 = 1'b1;
    @(posedge clk); #1 bus.invalid = 1'b1;
    @(posedge clk); #1;
    bus.invalid   = 1'b0;
    bus.cpu_rd_en = 1'b1;
    bus.cpu_addr  = 32'h100;
    model_clear();
    @(posedge clk); #2;
    chk("abort beat0 addr", 64'(bus.mem_addr), 64'h100);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("abort beat2 addr", 64'(bus.mem_addr), 64'h108);
    reset = 1'b1;
    #1;
    chk("mem_req drops on reset", 64'(bus.mem_req), 64'(0));
    bus.cpu_rd_en = 1'b0;
    @(posedge clk); #1;
    reset  = 1'b0;
    force0 = 1'b0;
    mon_en = 1'b1;
    do_op(1'b0, 32'h100, 32'h0, 1'b0);
    do_op(1'b0, 32'h108, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
